pipe_hazard_ctrl: RTL

//  Issue/stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB core pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based issue/stall/flush sequencer for a 5-stage pipeline.
// Optional stall statistics counter enabled by defining PIPE_STALL_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int WB_LAT = 3,
    parameter int MC_LAT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_mc,
    input  logic              br_taken,
    output logic              issue,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              mc_busy,
    output logic [15:0]       stall_cnt
);
    localparam int NR = 2 ** REG_AW;
    localparam int SW = $clog2((WB_LAT > MC_LAT ? WB_LAT : MC_LAT) + 1);
    localparam int MW = $clog2(MC_LAT) < 3 ? 3 : $clog2(MC_LAT);

    typedef enum logic {IDLE, MC_RUN} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mc_left_q, mc_left_d;
    logic [SW-1:0]   sb_q [NR];
    logic [SW-1:0]   sb_d [NR];
    logic            hazard;

    // no bypass network: a register is unreadable until its counter drains to zero
    assign hazard = id_valid && ((id_rs1 != '0 && sb_q[id_rs1] != '0) ||
                                 (id_rs2 != '0 && sb_q[id_rs2] != '0));

    assign issue    = !reset && id_valid && !hazard && state_q == IDLE && !br_taken;
    assign stall_id = !reset && !br_taken && (state_q == MC_RUN || hazard);
    assign stall_if = stall_id;
    assign flush_id = reset || (br_taken && state_q == IDLE);
    assign flush_ex = flush_id;
    assign mc_busy  = state_q == MC_RUN;

    always_comb begin
        for (int r = 0; r < NR; r++)
            sb_d[r] = (r != 0 && issue && id_we && id_rd == REG_AW'(r)) ?
                      (id_mc ? SW'(MC_LAT) : SW'(WB_LAT)) :
                      (sb_q[r] != '0 ? sb_q[r] - 1'b1 : sb_q[r]);
    end

    always_comb begin
        state_d   = state_q == IDLE ? ((issue && id_mc) ? MC_RUN : IDLE)
                                    : (mc_left_q == MW'(1) ? IDLE : MC_RUN);
        mc_left_d = state_q == IDLE ? ((issue && id_mc) ? MW'(MC_LAT - 1) : mc_left_q)
                                    : mc_left_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mc_left_q <= '0;
            sb_q      <= '{default: '0};
        end else begin
            state_q   <= state_d;
            mc_left_q <= mc_left_d;
            sb_q      <= sb_d;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (stall_id && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= 16'h0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule
